// File: rtl/sd_spi_cmd_controller_if.sv
// rtl/sd_spi_cmd_controller_if.sv - forwarded-command valid/ready handshake
interface sd_spi_cmd_controller_if;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_ready;

   modport master (output cmd_valid, output cmd_index, output cmd_arg, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_index, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/sd_spi_cmd_controller.sv
// rtl/sd_spi_cmd_controller.sv - SD SPI-mode command framer, CRC7 checker and responder
module sd_spi_cmd_controller #(
   parameter int          CRC_CHECK    = 1,
   parameter int          NCR_BYTES    = 1,
   parameter int          ACMD41_POLLS = 2,
   parameter logic [31:0] OCR          = 32'hC0FF8000
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       CS,
   input  logic [7:0] rx_byte,
   input  logic       rx_changed,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic       card_ready,
   output logic       crc_error,
   sd_spi_cmd_controller_if.master cmd
);
   localparam logic [3:0] NCR_N   = 4'(NCR_BYTES);
   localparam logic [7:0] POLLS_N = 8'(ACMD41_POLLS);

   typedef enum logic [2:0] {HUNT, FRAME, CHECK, DISPATCH, WAIT_NCR, RESP} state_t;

   state_t      state;
   logic        rx_changed_q;
   logic        be;
   logic [47:0] frame;
   logic [2:0]  byte_cnt;
   logic        idle;
   logic        app_flag;
   logic [7:0]  acmd_cnt;
   logic [39:0] resp;
   logic [2:0]  resp_cnt;
   logic [3:0]  ncr_cnt;
   logic        drop_resp;

   logic        crc_bad, is_cmd0, is_cmd8, is_cmd55, is_acmd41, is_cmd58;
   logic        known, illegal, go_dispatch, leave_idle, idle_next;
   logic [5:0]  idx;
   logic [31:0] arg;
   logic [7:0]  acmd_next, r1;
   logic [39:0] resp_next;
   logic [2:0]  len_next;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   assign be = rx_changed & ~rx_changed_q;

   // Decode of the completed frame; only consumed in CHECK.
   always_comb begin
      idx         = frame[45:40];
      arg         = frame[39:8];
      crc_bad     = (CRC_CHECK != 0) && (frame[7:0] != {crc7(frame[47:8]), 1'b1});
      is_cmd0     = (idx == 6'd0);
      is_cmd8     = (idx == 6'd8);
      is_cmd55    = (idx == 6'd55);
      is_acmd41   = (idx == 6'd41) && app_flag;
      is_cmd58    = (idx == 6'd58);
      known       = is_cmd0 | is_cmd8 | is_cmd55 | is_acmd41 | is_cmd58;
      acmd_next   = (acmd_cnt == 8'hFF) ? acmd_cnt : acmd_cnt + 8'd1;
      leave_idle  = is_acmd41 && (acmd_next >= POLLS_N);
      idle_next   = crc_bad ? idle : (is_cmd0 ? 1'b1 : (leave_idle ? 1'b0 : idle));
      illegal     = !crc_bad && !known && idle;
      go_dispatch = !crc_bad && !known && !idle;
      r1          = {4'b0000, crc_bad, illegal, 1'b0, idle_next};
      resp_next   = {r1, 32'h0};
      len_next    = 3'd1;
      if (!crc_bad && is_cmd8) begin
         resp_next = {r1, 16'h0000, 4'h0, arg[11:8], arg[7:0]};
         len_next  = 3'd5;
      end else if (!crc_bad && is_cmd58) begin
         resp_next = {r1, OCR};
         len_next  = 3'd5;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state         <= HUNT;
         rx_changed_q  <= 1'b0;
         frame         <= '0;
         byte_cnt      <= '0;
         idle          <= 1'b1;
         app_flag      <= 1'b0;
         acmd_cnt      <= '0;
         resp          <= '0;
         resp_cnt      <= '0;
         ncr_cnt       <= '0;
         drop_resp     <= 1'b0;
         tx_byte       <= 8'hFF;
         tx_load       <= 1'b0;
         card_ready    <= 1'b0;
         crc_error     <= 1'b0;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_index <= '0;
         cmd.cmd_arg   <= '0;
      end else begin
         rx_changed_q <= rx_changed;
         tx_load      <= 1'b0;
         if (CS && state != DISPATCH) begin
            state   <= HUNT;
            tx_byte <= 8'hFF;
         end else begin
            case (state)
               HUNT: if (be && rx_byte[7:6] == 2'b01) begin
                  frame    <= {40'h0, rx_byte};
                  byte_cnt <= 3'd1;
                  state    <= FRAME;
               end
               FRAME: if (be) begin
                  frame    <= {frame[39:0], rx_byte};
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt == 3'd5) state <= CHECK;
               end
               CHECK: begin
                  resp      <= resp_next;
                  resp_cnt  <= len_next;
                  ncr_cnt   <= '0;
                  drop_resp <= 1'b0;
                  if (crc_bad) begin
                     crc_error <= 1'b1;
                  end else begin
                     app_flag <= is_cmd55;
                     if (is_cmd0) begin
                        idle       <= 1'b1;
                        card_ready <= 1'b0;
                        acmd_cnt   <= '0;
                        crc_error  <= 1'b0;
                     end
                     if (is_acmd41) begin
                        acmd_cnt <= acmd_next;
                        if (leave_idle) begin
                           idle       <= 1'b0;
                           card_ready <= 1'b1;
                        end
                     end
                  end
                  if (go_dispatch) begin
                     cmd.cmd_valid <= 1'b1;
                     cmd.cmd_index <= idx;
                     cmd.cmd_arg   <= arg;
                     state         <= DISPATCH;
                  end else begin
                     state <= WAIT_NCR;
                  end
               end
               // A deselect while waiting still lets the handshake finish, but the R1 is dropped.
               DISPATCH: begin
                  if (cmd.cmd_ready) begin
                     cmd.cmd_valid <= 1'b0;
                     state         <= (CS || drop_resp) ? HUNT : WAIT_NCR;
                  end else if (CS) begin
                     drop_resp <= 1'b1;
                  end
               end
               WAIT_NCR: if (be) begin
                  tx_byte <= 8'hFF;
                  tx_load <= 1'b1;
                  ncr_cnt <= ncr_cnt + 4'd1;
                  if (ncr_cnt + 4'd1 >= NCR_N) state <= RESP;
               end
               RESP: if (be) begin
                  tx_load <= 1'b1;
                  if (resp_cnt != 3'd0) begin
                     tx_byte  <= resp[39:32];
                     resp     <= {resp[31:0], 8'h00};
                     resp_cnt <= resp_cnt - 3'd1;
                  end else begin
                     tx_byte <= 8'hFF;
                     state   <= HUNT;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sd_spi_cmd_controller.sv
// tb/tb_sd_spi_cmd_controller.sv - self-checking bench for sd_spi_cmd_controller
module tb_sd_spi_cmd_controller;
   localparam int          NCR   = 1;
   localparam int          POLLS = 2;
   localparam logic [31:0] OCR_V = 32'hC0FF8000;

   logic       CLK        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       CS         = 1'b1;
   logic [7:0] rx_byte    = 8'hFF;
   logic       rx_changed = 1'b0;
   logic [7:0] tx_byte;
   logic       tx_load;
   logic       card_ready;
   logic       crc_error;

   sd_spi_cmd_controller_if bus();

   sd_spi_cmd_controller #(
      .CRC_CHECK(1), .NCR_BYTES(NCR), .ACMD41_POLLS(POLLS), .OCR(OCR_V)
   ) dut (
      .CLK(CLK), .reset_n(reset_n), .CS(CS), .rx_byte(rx_byte), .rx_changed(rx_changed),
      .tx_byte(tx_byte), .tx_load(tx_load), .card_ready(card_ready), .crc_error(crc_error),
      .cmd(bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int load_cnt = 0;

   always @(negedge CLK) if (tx_load === 1'b1) load_cnt <= load_cnt + 1;

   // Reference card state
   bit         m_idle, m_app, m_ready, m_crcerr, m_disp;
   int         m_cnt;
   logic [7:0] exp_q[$];

   function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
      logic [46:0] v;
      v = {msg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
      return v[6:0];
   endfunction

   function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
   endfunction

   task automatic model_reset();
      m_idle = 1; m_app = 0; m_ready = 0; m_crcerr = 0; m_cnt = 0;
   endtask

   task automatic model_exec(input logic [47:0] f);
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  r1;
      bit          bad;
      idx = f[45:40];
      arg = f[39:8];
      bad = (f[7:0] != {crc7_ref(f[47:8]), 1'b1});
      exp_q.delete();
      m_disp = 0;
      if (bad) begin
         m_crcerr = 1;
         exp_q.push_back(8'h08 | {7'b0, m_idle});
      end else if (idx == 0) begin
         m_idle = 1; m_ready = 0; m_app = 0; m_cnt = 0; m_crcerr = 0;
         exp_q.push_back(8'h01);
      end else if (idx == 8) begin
         m_app = 0;
         r1 = {7'b0, m_idle};
         exp_q = '{r1, 8'h00, 8'h00, {4'h0, arg[11:8]}, arg[7:0]};
      end else if (idx == 55) begin
         m_app = 1;
         exp_q.push_back({7'b0, m_idle});
      end else if (idx == 58) begin
         m_app = 0;
         r1 = {7'b0, m_idle};
         exp_q = '{r1, OCR_V[31:24], OCR_V[23:16], OCR_V[15:8], OCR_V[7:0]};
      end else if (idx == 41 && m_app) begin
         m_app = 0;
         m_cnt++;
         if (m_cnt >= POLLS) begin m_idle = 0; m_ready = 1; end
         exp_q.push_back({7'b0, m_idle});
      end else begin
         m_app = 0;
         if (m_idle) exp_q.push_back(8'h05);
         else begin m_disp = 1; exp_q.push_back(8'h00); end
      end
   endtask

   task automatic xfer(input logic [7:0] b, output logic [7:0] t);
      @(negedge CLK); rx_byte = b; rx_changed = 1'b1;
      repeat (4) @(negedge CLK);
      rx_changed = 1'b0;
      repeat (5) @(negedge CLK);
      t = tx_byte;
   endtask

   task automatic run_cmd(input logic [47:0] f, input string name);
      logic [7:0] t, e;
      int ld0, slots;
      bit ok;
      model_exec(f);
      ld0 = load_cnt;
      ok = 1;
      for (int i = 0; i < 6; i++) begin
         xfer(f[47-8*i -: 8], t);
         if (t !== 8'hFF) ok = 0;
      end
      n_checks++;
      if (!ok || load_cnt != ld0) begin
         n_fail++;
         $display("FAIL %s frame_idle: tx_ok=%0d loads=%0d, required tx 0xFF and 0 loads", name, ok, load_cnt - ld0);
      end
      if (m_disp) begin
         n_checks++;
         if (bus.cmd_valid !== 1'b1 || bus.cmd_index !== f[45:40] || bus.cmd_arg !== f[39:8]) begin
            n_fail++;
            $display("FAIL %s dispatch: valid=%b idx=%0d arg=%h, required 1 %0d %h",
                     name, bus.cmd_valid, bus.cmd_index, bus.cmd_arg, f[45:40], f[39:8]);
         end
         ok = 1;
         for (int i = 0; i < 3; i++) begin
            xfer(8'hFF, t);
            if (t !== 8'hFF || bus.cmd_valid !== 1'b1) ok = 0;
         end
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s dispatch_hold: tx=%h valid=%b, required FF 1", name, t, bus.cmd_valid);
         end
         @(negedge CLK); bus.cmd_ready = 1'b1;
         @(negedge CLK); bus.cmd_ready = 1'b0;
         n_checks++;
         if (bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dispatch_accept: valid=%b, required 0", name, bus.cmd_valid);
         end
      end
      ld0 = load_cnt;
      slots = NCR + exp_q.size() + 1;
      for (int i = 0; i < slots; i++) begin
         xfer(8'hFF, t);
         e = (i < NCR || i >= NCR + exp_q.size()) ? 8'hFF : exp_q[i - NCR];
         n_checks++;
         if (t !== e) begin
            n_fail++;
            $display("FAIL %s slot%0d: tx=%h, required %h", name, i, t, e);
         end
      end
      n_checks++;
      if (load_cnt - ld0 != slots || card_ready !== m_ready || crc_error !== m_crcerr) begin
         n_fail++;
         $display("FAIL %s status: loads=%0d card_ready=%b crc_error=%b, required %0d %b %b",
                  name, load_cnt - ld0, card_ready, crc_error, slots, m_ready, m_crcerr);
      end
   endtask

   task automatic make_ready();
      run_cmd(48'h400000000095, "cmd0");
      for (int i = 0; i < POLLS; i++) begin
         run_cmd(48'h770000000065, "cmd55");
         run_cmd(48'h694000000077, "acmd41");
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (tx_byte !== 8'hFF || tx_load !== 1'b0 || bus.cmd_valid !== 1'b0 || card_ready !== 1'b0 ||
          crc_error !== 1'b0 || bus.cmd_index !== 6'd0 || bus.cmd_arg !== 32'd0) begin
         n_fail++;
         $display("FAIL reset: tx=%h load=%b valid=%b ready=%b crcerr=%b idx=%0d arg=%h, required FF 0 0 0 0 0 0",
                  tx_byte, tx_load, bus.cmd_valid, card_ready, crc_error, bus.cmd_index, bus.cmd_arg);
      end
      reset_n = 1'b1;
      model_reset();
      @(negedge CLK); CS = 1'b0;
   endtask

   task automatic test_cmd0();
      run_cmd(48'h400000000095, "cmd0");
   endtask

   task automatic test_cmd8();
      run_cmd(48'h48000001AA87, "cmd8");
      for (int i = 0; i < 3; i++) run_cmd(make_cmd(6'd8, $urandom), "cmd8_rand");
   endtask

   task automatic test_acmd41();
      make_ready();
      run_cmd(48'h7A00000000FD, "cmd58");
   endtask

   task automatic test_dispatch();
      run_cmd(make_cmd(6'd17, 32'h00000200), "cmd17");
      for (int i = 0; i < 4; i++) run_cmd(make_cmd(6'($urandom_range(9, 40)), $urandom), "fwd_rand");
   endtask

   task automatic test_crc_error();
      run_cmd(48'h400000000095, "cmd0");
      run_cmd(48'h400000000000, "cmd0_badcrc");
      run_cmd(48'h400000000095, "cmd0_clear");
      run_cmd(make_cmd(6'd17, 32'h1234), "illegal_idle");
   endtask

   task automatic test_cs_abort();
      logic [7:0] t;
      logic [47:0] f;
      int ld0;
      xfer(8'h40, t); xfer(8'h00, t); xfer(8'h00, t);
      @(negedge CLK); CS = 1'b1;
      repeat (2) @(negedge CLK);
      xfer(8'h00, t); xfer(8'h00, t); xfer(8'h95, t);
      n_checks++;
      if (tx_byte !== 8'hFF) begin
         n_fail++;
         $display("FAIL cs_abort_tx: tx=%h, required FF", tx_byte);
      end
      @(negedge CLK); CS = 1'b0;
      run_cmd(48'h400000000095, "cmd0_after_abort");
      make_ready();
      f = make_cmd(6'd24, 32'h00000400);
      model_exec(f);
      for (int i = 0; i < 6; i++) xfer(f[47-8*i -: 8], t);
      @(negedge CLK); CS = 1'b1;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (bus.cmd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL cs_dispatch_hold: valid=%b, required 1", bus.cmd_valid);
      end
      bus.cmd_ready = 1'b1;
      @(negedge CLK); bus.cmd_ready = 1'b0;
      @(negedge CLK); CS = 1'b0;
      ld0 = load_cnt;
      for (int i = 0; i < 3; i++) xfer(8'hFF, t);
      n_checks++;
      if (bus.cmd_valid !== 1'b0 || t !== 8'hFF || load_cnt != ld0) begin
         n_fail++;
         $display("FAIL cs_dispatch_drop: valid=%b tx=%h loads=%0d, required 0 FF 0", bus.cmd_valid, t, load_cnt - ld0);
      end
   endtask

   task automatic test_random();
      logic [47:0] f;
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 6))
            0: f = make_cmd(6'd0, $urandom);
            1: f = make_cmd(6'd8, $urandom);
            2: f = make_cmd(6'd55, $urandom);
            3: f = make_cmd(6'd41, $urandom);
            4: f = make_cmd(6'd58, $urandom);
            5: f = make_cmd(6'($urandom_range(0, 63)), $urandom);
            default: begin
               f = make_cmd(6'($urandom_range(0, 63)), $urandom);
               f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
            end
         endcase
         run_cmd(f, "random");
      end
   endtask

   task automatic test_reset_midop();
      logic [7:0] t;
      logic [47:0] f;
      make_ready();
      run_cmd(make_cmd(6'd58, 32'h0) ^ 48'h1, "cmd58_badcrc");
      f = make_cmd(6'd18, 32'hDEADBEEF);
      for (int i = 0; i < 6; i++) xfer(f[47-8*i -: 8], t);
      n_checks++;
      if (bus.cmd_valid !== 1'b1 || card_ready !== 1'b1 || crc_error !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_pre: valid=%b ready=%b crcerr=%b, required 1 1 1", bus.cmd_valid, card_ready, crc_error);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (tx_byte !== 8'hFF || tx_load !== 1'b0 || bus.cmd_valid !== 1'b0 || card_ready !== 1'b0 ||
          crc_error !== 1'b0 || bus.cmd_index !== 6'd0 || bus.cmd_arg !== 32'd0) begin
         n_fail++;
         $display("FAIL midop_reset: tx=%h valid=%b ready=%b crcerr=%b idx=%0d arg=%h, required FF 0 0 0 0 0",
                  tx_byte, bus.cmd_valid, card_ready, crc_error, bus.cmd_index, bus.cmd_arg);
      end
      repeat (2) @(negedge CLK);
      reset_n = 1'b1;
      model_reset();
      run_cmd(make_cmd(6'd17, 32'h0), "illegal_after_reset");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_ready = 1'b0;
      model_reset();
      test_reset();
      test_cmd0();
      test_cmd8();
      test_acmd41();
      test_dispatch();
      test_crc_error();
      test_cs_abort();
      test_random();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
